// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers hex digits and decimal points from a
// time-multiplexed 7-segment bus, committing a digit once its pair is stable.
module seven_segment_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int EW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   digit_value,
  output logic [DIGITS-1:0]     digit_dp,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update_pulse,
  output logic                  error_pulse,
  output logic [EW-1:0]         error_digit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_s_seg;
  logic [DIGITS-1:0]   r_s_sel;
  logic [7:0]          r_ref_seg;
  logic [DIGITS-1:0]   r_ref_sel;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_valid;
  logic                r_upd;
  logic                r_err;
  logic [EW-1:0]       r_err_digit;

  logic                w_onehot;
  logic                w_same;
  logic [EW-1:0]       w_idx;
  logic [3:0]          w_nib;
  logic                w_legal;
  logic                w_blank;

  // Sample the bus every cycle; the previous sample is the stability reference.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s_seg   <= '0;
      r_s_sel   <= '0;
      r_ref_seg <= '0;
      r_ref_sel <= '0;
    end else begin
      r_s_seg   <= seg_in;
      r_s_sel   <= digit_sel;
      r_ref_seg <= r_s_seg;
      r_ref_sel <= r_s_sel;
    end
  end

  // Select qualification, stability compare and digit index.
  always_comb begin
    w_onehot = (r_s_sel != '0) &&
               ((r_s_sel & (r_s_sel - DIGITS'(1))) == '0);
    w_same   = (r_s_sel == r_ref_sel) && (r_s_seg == r_ref_seg);
    w_idx    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_s_sel[i]) w_idx = EW'(i);
    end
  end

  // Segment pattern to nibble; anything unlisted and non-blank is illegal.
  always_comb begin
    w_nib   = 4'h0;
    w_legal = 1'b1;
    w_blank = (r_s_seg[6:0] == 7'h00);
    case (r_s_seg[6:0])
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // Stability FSM with registered commit outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_value     <= '0;
      r_dp        <= '0;
      r_valid     <= '0;
      r_upd       <= 1'b0;
      r_err       <= 1'b0;
      r_err_digit <= '0;
    end else begin
      r_upd <= 1'b0;
      r_err <= 1'b0;
      if (!w_onehot) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= COUNT;
            r_cnt   <= CW'(1);
          end
          COUNT: begin
            if (!w_same) begin
              r_cnt <= CW'(1);
            end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
              r_cnt   <= CW'(STABLE_CYCLES);
              r_state <= LOCKED;
              if (w_blank) begin
                r_valid[w_idx] <= 1'b0;
                r_dp[w_idx]    <= r_s_seg[7];
              end else if (w_legal) begin
                r_value[{w_idx, 2'b00} +: 4] <= w_nib;
                r_dp[w_idx]    <= r_s_seg[7];
                r_valid[w_idx] <= 1'b1;
                r_upd          <= 1'b1;
              end else begin
                r_valid[w_idx] <= 1'b0;
                r_err          <= 1'b1;
                r_err_digit    <= w_idx;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          LOCKED: begin
            if (!w_same) begin
              r_state <= COUNT;
              r_cnt   <= CW'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign digit_value  = r_value;
  assign digit_dp     = r_dp;
  assign digit_valid  = r_valid;
  assign update_pulse = r_upd;
  assign error_pulse  = r_err;
  assign error_digit  = r_err_digit;

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: table-driven checks of commit timing, decode,
// blank/illegal handling, glitch recommit and reset mid-count.
module tb_seven_segment_reader;

  logic        clock;
  logic        reset;
  logic [7:0]  seg_in;
  logic [3:0]  digit_sel;
  logic [15:0] digit_value;
  logic [3:0]  digit_dp;
  logic [3:0]  digit_valid;
  logic        update_pulse;
  logic        error_pulse;
  logic [1:0]  error_digit;

  int nchk = 0;
  int nerr = 0;

  seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .seg_in       (seg_in),
    .digit_sel    (digit_sel),
    .digit_value  (digit_value),
    .digit_dp     (digit_dp),
    .digit_valid  (digit_valid),
    .update_pulse (update_pulse),
    .error_pulse  (error_pulse),
    .error_digit  (error_digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  seg;
    int          hold;
    int          upd;
    int          err;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  vld;
    logic [1:0]  ed;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [3:0] sel, logic [7:0] seg, int hold,
                              int upd, int err, logic [15:0] val,
                              logic [3:0] dp, logic [3:0] vld,
                              logic [1:0] ed);
    vec_t v;
    v.sel = sel; v.seg = seg; v.hold = hold;
    v.upd = upd; v.err = err; v.val = val;
    v.dp = dp; v.vld = vld; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(logic [3:0] sel, logic [7:0] seg, int hold,
                     output int u, output int e);
    digit_sel = sel;
    seg_in    = seg;
    u = 0;
    e = 0;
    repeat (hold) begin
      @(posedge clock);
      #1;
      if (update_pulse) u++;
      if (error_pulse) e++;
      if (update_pulse && error_pulse) chk("pulse_excl", 1, 0);
    end
  endtask

  task automatic chk_outs(string tag, logic [15:0] val, logic [3:0] dp,
                          logic [3:0] vld, logic [1:0] ed);
    chk({tag, "_value"}, 32'(digit_value), 32'(val));
    chk({tag, "_dp"},    32'(digit_dp),    32'(dp));
    chk({tag, "_valid"}, 32'(digit_valid), 32'(vld));
    chk({tag, "_edig"},  32'(error_digit), 32'(ed));
  endtask

  logic [6:0] pat [16];

  initial begin
    int u;
    int e;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vq.push_back(mk(4'b0001, 8'h06, 4, 1, 0, 16'h0001, 4'h0, 4'b0001, 2'd0));
    for (int i = 0; i < 16; i++) begin
      logic [15:0] ev;
      ev = 16'h0001;
      ev[7:4] = 4'(i);
      vq.push_back(mk(4'b0010, {1'b0, pat[i]}, 4, 1, 0, ev,
                      4'h0, 4'b0011, 2'd0));
    end
    vq.push_back(mk(4'b0100, 8'hFF, 5, 1, 0, 16'h08F1, 4'b0100, 4'b0111, 2'd0));
    vq.push_back(mk(4'b1000, 8'h3F, 2, 0, 0, 16'h08F1, 4'b0100, 4'b0111, 2'd0));
    vq.push_back(mk(4'b1000, 8'h06, 4, 1, 0, 16'h18F1, 4'b0100, 4'b1111, 2'd0));
    vq.push_back(mk(4'b0001, 8'h55, 4, 0, 1, 16'h18F1, 4'b0100, 4'b1110, 2'd0));
    vq.push_back(mk(4'b0011, 8'h06, 4, 0, 0, 16'h18F1, 4'b0100, 4'b1110, 2'd0));
    vq.push_back(mk(4'b0010, 8'h80, 4, 0, 0, 16'h18F1, 4'b0110, 4'b1100, 2'd0));
    vq.push_back(mk(4'b0100, 8'h7E, 4, 0, 1, 16'h18F1, 4'b0110, 4'b1000, 2'd2));
    vq.push_back(mk(4'b0001, 8'h5B, 4, 1, 0, 16'h18F2, 4'b0110, 4'b1001, 2'd2));
    vq.push_back(mk(4'b0001, 8'h4F, 1, 0, 0, 16'h18F2, 4'b0110, 4'b1001, 2'd2));
    vq.push_back(mk(4'b0001, 8'h5B, 4, 1, 0, 16'h18F2, 4'b0110, 4'b1001, 2'd2));
    vq.push_back(mk(4'b0010, 8'h07, 4, 1, 0, 16'h1872, 4'b0100, 4'b1011, 2'd2));
    vq.push_back(mk(4'b0100, 8'h6D, 4, 1, 0, 16'h1572, 4'b0000, 4'b1111, 2'd2));

    reset     = 1'b1;
    seg_in    = 8'h00;
    digit_sel = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_upd", 32'(update_pulse), 0);
    chk("rst_err", 32'(error_pulse), 0);
    chk_outs("rst", 16'h0, 4'h0, 4'h0, 2'd0);
    reset = 1'b0;

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run(vq[i].sel, vq[i].seg, vq[i].hold, u, e);
      chk({tag, "_upd"}, 32'(u), 32'(vq[i].upd));
      chk({tag, "_err"}, 32'(e), 32'(vq[i].err));
      chk_outs(tag, vq[i].val, vq[i].dp, vq[i].vld, vq[i].ed);
    end

    run(4'b1000, 8'h66, 2, u, e);
    chk("mid_upd", 32'(u + e), 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rstm_upd", 32'(update_pulse), 0);
    chk("rstm_err", 32'(error_pulse), 0);
    chk_outs("rstm", 16'h0, 4'h0, 4'h0, 2'd0);
    reset = 1'b0;
    run(4'b1000, 8'h66, 2, u, e);
    chk("post_pulses", 32'(u + e), 0);
    chk_outs("post", 16'h0, 4'h0, 4'h0, 2'd0);
    run(4'b1000, 8'h66, 2, u, e);
    chk("recov_upd", 32'(u), 1);
    chk("recov_err", 32'(e), 0);
    chk_outs("recov", 16'h4000, 4'h0, 4'b1000, 2'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
